// File: rtl/lfsr_keystream.sv
// lfsr_keystream
// Burst keystream generator built on a runtime-configurable LFSR.
// A burst of `len` words is requested with `start`; each word is built from
// W consecutive LFSR steps (bit k = state[0] before the step, first bit in
// out_data[0]) and then offered on a valid/ready handshake.
//
// Parameters:
//   N     - LFSR width (N >= 2)
//   W     - keystream word width (1 <= W <= N)
//   CNT_W - burst length counter width
//
// Ports:
//   clk       in  1      clock, rising edge
//   rst       in  1      synchronous active-high reset (loads seed)
//   taps      in  N      feedback tap mask, captured at burst start
//   seed      in  N      value loaded by rst or ld
//   ld        in  1      load seed, abort any burst, no done
//   mode      in  1      0 = Galois, 1 = Fibonacci, captured at burst start
//   start     in  1      begin a burst (ignored while busy)
//   len       in  CNT_W  words in burst (0 -> immediate done)
//   out_data  out W      keystream word
//   out_valid out 1      word available
//   out_ready in  1      consumer accepts word
//   busy      out 1      burst in progress
//   done      out 1      one-cycle pulse after a normally completed burst
//   state_o   out N      current LFSR register
//   lockup    out 1      sticky all-zero-state flag
//
// Optional feature: define LFSR_LOCKUP_DET_EN to enable all-zero state
// detection (sticky lockup, burst aborted). Without it lockup is tied to 0
// and an all-zero state simply yields all-zero words.
module lfsr_keystream #(
    parameter int N     = 48,
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     taps,
    input  logic [N-1:0]     seed,
    input  logic             ld,
    input  logic             mode,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [N-1:0]     state_o,
    output logic             lockup
);

    localparam int BC_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        HOLD = 2'd2
    } fsm_t;

    fsm_t             fsm_reg;
    logic [N-1:0]     lfsr_reg;
    logic [N-1:0]     taps_reg;
    logic             mode_reg;
    logic [CNT_W-1:0] rem_reg;
    logic [BC_W-1:0]  bit_cnt_reg;
    logic [W-1:0]     word_reg;
    logic             valid_reg;
    logic             done_reg;

    logic [N-1:0]     galois_next;
    logic [N-1:0]     fib_next;
    logic [N-1:0]     step_next;
    logic [W-1:0]     word_next;

    // Galois step: shift right, XOR taps in when the outgoing bit is 1.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_galois
            if (gi == N - 1) begin : g_top
                assign galois_next[gi] = lfsr_reg[0] & taps_reg[gi];
            end else begin : g_mid
                assign galois_next[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & taps_reg[gi]);
            end
        end
    endgenerate

    // Fibonacci step: parity of tapped bits enters at the MSB.
    assign fib_next  = {^(lfsr_reg & taps_reg), lfsr_reg[N-1:1]};
    assign step_next = mode_reg ? fib_next : galois_next;

    // Key bit enters at the top so that after W shifts the first bit sits in bit 0.
    generate
        if (W == 1) begin : g_word1
            assign word_next = lfsr_reg[0];
        end else begin : g_wordn
            assign word_next = {lfsr_reg[0], word_reg[W-1:1]};
        end
    endgenerate

`ifdef LFSR_LOCKUP_DET_EN
    logic lockup_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg     <= IDLE;
            lfsr_reg    <= seed;
            taps_reg    <= '0;
            mode_reg    <= 1'b0;
            rem_reg     <= '0;
            bit_cnt_reg <= '0;
            word_reg    <= '0;
            valid_reg   <= 1'b0;
            done_reg    <= 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
            lockup_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (ld) begin
                // Load wins over everything else and never reports done.
                fsm_reg     <= IDLE;
                lfsr_reg    <= seed;
                rem_reg     <= '0;
                bit_cnt_reg <= '0;
                valid_reg   <= 1'b0;
`ifdef LFSR_LOCKUP_DET_EN
                lockup_reg  <= 1'b0;
`endif
            end else begin
                case (fsm_reg)
                    IDLE: begin
                        if (start) begin
                            if (len == '0) begin
                                done_reg <= 1'b1;
`ifdef LFSR_LOCKUP_DET_EN
                            end else if (lfsr_reg == '0) begin
                                lockup_reg <= 1'b1;
`endif
                            end else begin
                                taps_reg    <= taps;
                                mode_reg    <= mode;
                                rem_reg     <= len;
                                bit_cnt_reg <= '0;
                                fsm_reg     <= GEN;
                            end
                        end
                    end
                    GEN: begin
                        lfsr_reg <= step_next;
                        word_reg <= word_next;
                        if (bit_cnt_reg == BC_W'(W - 1)) begin
                            bit_cnt_reg <= '0;
                            fsm_reg     <= HOLD;
                            valid_reg   <= 1'b1;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
`ifdef LFSR_LOCKUP_DET_EN
                        // Later assignments override the normal progression.
                        if (step_next == '0) begin
                            lockup_reg  <= 1'b1;
                            fsm_reg     <= IDLE;
                            valid_reg   <= 1'b0;
                            bit_cnt_reg <= '0;
                        end
`endif
                    end
                    HOLD: begin
                        if (out_ready) begin
                            valid_reg <= 1'b0;
                            rem_reg   <= rem_reg - CNT_W'(1);
                            if (rem_reg == CNT_W'(1)) begin
                                fsm_reg  <= IDLE;
                                done_reg <= 1'b1;
                            end else begin
                                fsm_reg  <= GEN;
                            end
                        end
                    end
                    default: fsm_reg <= IDLE;
                endcase
            end
        end
    end

    assign out_data  = word_reg;
    assign out_valid = valid_reg;
    assign busy      = (fsm_reg != IDLE);
    assign done      = done_reg;
    assign state_o   = lfsr_reg;
`ifdef LFSR_LOCKUP_DET_EN
    assign lockup    = lockup_reg;
`else
    assign lockup    = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_keystream.sv
// Testbench for lfsr_keystream (N=4, W=4). A queue-based reference model
// plans each word's LFSR trajectory up front and a negedge compare process
// checks every DUT output against it; directed scenarios pin the model with
// hand-computed literals, followed by a randomized phase.
module tb_lfsr_keystream;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int CNT_W = 8;
`ifdef LFSR_LOCKUP_DET_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N-1:0]     taps;
    logic [N-1:0]     seed;
    logic             ld;
    logic             mode;
    logic             start;
    logic [CNT_W-1:0] len;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [N-1:0]     state_o;
    logic             lockup;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    lfsr_keystream #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .taps(taps), .seed(seed), .ld(ld), .mode(mode),
        .start(start), .len(len), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .state_o(state_o),
        .lockup(lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [N-1:0]     m_lfsr;
    logic [N-1:0]     m_taps;
    logic             m_mode;
    logic [W-1:0]     m_word;
    int               m_left;
    bit               m_busy, m_valid, m_done, m_lockup;
    logic [N-1:0]     m_steps[$];

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s, input logic [N-1:0] t, input logic md);
        if (md)
            return ({N{1'b0}} | N'(^(s & t)) << (N - 1)) | (s >> 1);
        else if (s[0])
            return (s >> 1) ^ t;
        else
            return s >> 1;
    endfunction

    // Precompute one word and the W states the LFSR passes through.
    task automatic plan_word();
        logic [N-1:0] s;
        s = m_lfsr;
        m_word = '0;
        m_steps.delete();
        for (int i = 0; i < W; i++) begin
            m_word[i] = s[0];
            s = lfsr_next(s, m_taps, m_mode);
            m_steps.push_back(s);
        end
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (rst || ld) begin
            m_lfsr = seed; m_busy = 0; m_valid = 0; m_lockup = 0; m_steps.delete();
        end else if (!m_busy) begin
            if (start) begin
                if (len == 0) m_done = 1'b1;
                else if (LK && m_lfsr == 0) m_lockup = 1'b1;
                else begin
                    m_busy = 1; m_taps = taps; m_mode = mode; m_left = int'(len);
                    plan_word();
                end
            end
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 0;
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_done = 1; end
                else plan_word();
            end
        end else begin
            m_lfsr = m_steps.pop_front();
            if (LK && m_lfsr == 0) begin
                m_lockup = 1; m_busy = 0; m_steps.delete();
            end else if (m_steps.size() == 0) begin
                m_valid = 1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, m_busy);
            check("out_valid", out_valid, m_valid);
            check("done", done, m_done);
            check("state_o", state_o, m_lfsr);
            check("lockup", lockup, m_lockup);
            if (m_valid) check("out_data", out_data, m_word);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_ld(input logic [N-1:0] s);
        seed = s; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic start_burst(input int l, input logic [N-1:0] t, input logic md, output int cyc);
        int c;
        start = 1'b1; len = CNT_W'(l); taps = t; mode = md;
        @(negedge clk);
        start = 1'b0;
        wait_valid(c);
        cyc = c + 1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int cyc;

    initial begin
        rst = 1'b1; seed = 4'hA; taps = '0; ld = 0; mode = 0; start = 0; len = '0; out_ready = 0;
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_state_o", state_o, 4'hA);
        check("rst_out_data", out_data, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_lockup", lockup, 1'b0);
        rst = 1'b0;

        // Galois single word
        do_ld(4'b0001);
        start_burst(1, 4'b1100, 1'b0, cyc);
        check("gal_latency", cyc, W + 1);
        check("gal_word", out_data, 4'h9);
        check("gal_state", state_o, 4'b1101);
        handshake();
        check("gal_done", done, 1'b1);
        check("gal_busy", busy, 1'b0);
        @(negedge clk);
        check("gal_done_pulse", done, 1'b0);

        // Fibonacci single word
        do_ld(4'b0001);
        start_burst(1, 4'b0011, 1'b1, cyc);
        check("fib_word", out_data, 4'h1);
        check("fib_state", state_o, 4'b1001);
        handshake();
        @(negedge clk);

        // Galois len=2 with a 3-cycle stall on word 1
        do_ld(4'b0001);
        start_burst(2, 4'b1100, 1'b0, cyc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_word", out_data, 4'h9);
            check("stall_state", state_o, 4'b1101);
        end
        handshake();
        check("mid_done", done, 1'b0);
        wait_valid(cyc);
        check("word2", out_data, 4'h5);
        check("word2_state", state_o, 4'b0111);
        handshake();
        check("len2_done", done, 1'b1);
        @(negedge clk);
        check("len2_done_pulse", done, 1'b0);

        // ld during GEN of word 2 of a len=3 burst
        do_ld(4'b0001);
        start_burst(3, 4'b1100, 1'b0, cyc);
        handshake();
        @(negedge clk);
        do_ld(4'h6);
        check("ld_state", state_o, 4'h6);
        check("ld_busy", busy, 1'b0);
        check("ld_valid", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("ld_no_done", done, 1'b0);
            @(negedge clk);
        end

        // len = 0
        start = 1'b1; len = '0;
        @(negedge clk);
        start = 1'b0;
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b0);
        check("len0_state", state_o, 4'h6);
        @(negedge clk);
        check("len0_pulse", done, 1'b0);

        // all-zero state
        do_ld(4'b0000);
`ifdef LFSR_LOCKUP_DET_EN
        start = 1'b1; len = CNT_W'(1); taps = 4'b1100; mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("lk_set", lockup, 1'b1);
        check("lk_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("lk_no_valid", out_valid, 1'b0);
        end
        do_ld(4'b0001);
        check("lk_clear", lockup, 1'b0);
`else
        start_burst(1, 4'b1100, 1'b0, cyc);
        check("zero_word", out_data, 4'h0);
        check("zero_state", state_o, 4'h0);
        check("zero_lockup", lockup, 1'b0);
        handshake();
        @(negedge clk);
`endif

        // randomized phase
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            ld        = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 3) == 0);
            len       = CNT_W'($urandom_range(0, 3));
            taps      = N'($urandom);
            seed      = N'($urandom);
            mode      = 1'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        rst = 0; ld = 0; start = 0; out_ready = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_keystream.md
LFSR_KEYSTREAM -- requirements
Module: lfsr_keystream

Interface
REQ-001 SHALL have parameter N, default 48, LFSR state width (N>=2).
REQ-002 SHALL have parameter W, default 8, keystream word width (1<=W<=N).
REQ-003 SHALL have parameter CNT_W, default 16, burst length counter width.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; no other clock or reset.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port taps  in  N  feedback tap mask.
REQ-008 SHALL have port seed  in  N  load value.
REQ-009 SHALL have port ld  in  1  load seed and abort burst.
REQ-010 SHALL have port mode  in  1  0=Galois, 1=Fibonacci.
REQ-011 SHALL have port start  in  1  begin burst.
REQ-012 SHALL have port len  in  CNT_W  number of words in burst.
REQ-013 SHALL have port out_data  out  W  keystream word.
REQ-014 SHALL have port out_valid  out  1  word available.
REQ-015 SHALL have port out_ready  in  1  consumer accepts word.
REQ-016 SHALL have port busy  out  1  burst in progress (state != IDLE).
REQ-017 SHALL have port done  out  1  one-cycle pulse, burst completed normally.
REQ-018 SHALL have port state_o  out  N  current LFSR register.
REQ-019 SHALL have port lockup  out  1  all-zero state detected (see Configuration).

Function
REQ-020 SHALL implement FSM states IDLE, GEN, HOLD.
REQ-021 In IDLE with start=1 and len!=0, SHALL latch taps, mode, len and go to GEN; with len=0, SHALL stay IDLE and pulse done next cycle.
REQ-022 In GEN, SHALL advance LFSR one step per cycle for exactly W cycles, shifting key bit k=state[0] (pre-step) into the word so the first bit lands in out_data[0].
REQ-023 Galois step: state[0] ? (state>>1)^taps : state>>1.
REQ-024 Fibonacci step: {^(state&taps), state[N-1:1]}.
REQ-025 After the W-th step, SHALL enter HOLD with out_valid=1; first word visible W+1 cycles after the start cycle.
REQ-026 In HOLD, LFSR and out_data SHALL hold while out_ready=0.
REQ-027 On out_valid&out_ready, SHALL decrement remaining count; if more words remain, go to GEN (out_valid=0); else go to IDLE and pulse done the following cycle.
REQ-028 start while busy SHALL be ignored; taps/mode changes during a burst SHALL have no effect.
REQ-029 ld=1 in any state SHALL load seed into LFSR next cycle, force IDLE, clear out_valid, suppress done; ld has priority over start and handshake.
REQ-030 In IDLE without ld, LFSR SHALL hold its value.

Reset
REQ-031 On rst: state_o=seed, FSM=IDLE, out_data=0, out_valid=0, busy=0, done=0, lockup=0, counters=0.
REQ-032 rst SHALL override ld, start and handshake, including mid-burst.

Configuration
REQ-033 Macro LFSR_LOCKUP_DET_EN defined: all-zero LFSR state at burst start or after any GEN step SHALL set sticky lockup=1, abort to IDLE, clear out_valid and suppress done; lockup cleared only by ld or rst.
REQ-034 Macro undefined: lockup SHALL be constant 0 and an all-zero state SHALL produce all-zero words normally.

Verification
REQ-035 N=4,W=4,mode=0,taps=4'b1100,seed=4'b0001,len=1 -> out_data=4'h9, state_o=4'b1101, out_valid in cycle start+5, done one cycle after handshake.
REQ-036 N=4,W=4,mode=1,taps=4'b0011,seed=4'b0001,len=1 -> out_data=4'h1, state_o=4'b1001.
REQ-037 Galois case, len=2, out_ready low 3 cycles on word 1 -> out_data/state_o stable during stall, 2 words delivered, exactly one done pulse.
REQ-038 ld asserted during GEN of word 2 of len=3 -> state_o=seed next cycle, busy=0, out_valid=0, no done.
REQ-039 start with len=0 -> done pulse next cycle, busy stays 0, state_o unchanged.
REQ-040 With LFSR_LOCKUP_DET_EN, seed=0, start len=1 -> lockup=1, busy=0, no out_valid; ld with seed=1 clears lockup.
